// File: rtl/issue_params_pkg.sv
// Instruction and issued-payload formats for the operand issue stage.
package issue_params;
    import register_file_params::*;

    localparam int OPCODE_WIDTH = 8;

    typedef logic [OPCODE_WIDTH-1:0]              opcode_t;
    typedef logic [REGISTER_DESCRIPTOR_WIDTH-1:0] reg_idx_t;
    typedef logic [OPERAND_WIDTH-1:0]             operand_t;

    typedef struct packed {
        opcode_t  opcode;
        reg_idx_t src0;
        reg_idx_t src1;
        reg_idx_t dst;
        logic     has_dst;
    } issue_instr_t;

    typedef struct packed {
        opcode_t  opcode;
        reg_idx_t dst;
        operand_t op0;
        operand_t op1;
    } issue_out_t;

    // r0 is hardwired, so writing it never needs a reservation.
    function automatic logic needs_reservation(input issue_instr_t instr);
        return instr.has_dst && (instr.dst != '0);
    endfunction
endpackage

// File: rtl/register_file_params_pkg.sv
// Geometry shared with global_register: register index width, data width and register count.
package register_file_params;
    localparam int REGISTER_DESCRIPTOR_WIDTH = 4;
    localparam int OPERAND_WIDTH             = 16;
    localparam int REGISTER_SIZE             = 1 << REGISTER_DESCRIPTOR_WIDTH;
endpackage

// File: rtl/operand_issue_stage_slot.sv
// One-entry valid/ready pipeline register; a load always wins over an unload in the same cycle.
module issue_slot #(
    parameter type payload_t = logic
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     unload,
    input  payload_t data_in,
    output logic     valid,
    output payload_t data_out
);
    typedef enum logic {EMPTY, FULL} slot_state_t;

    slot_state_t state_q, state_d;
    payload_t    data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = FULL;
            data_d  = data_in;
        end else if (unload) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid    = (state_q == FULL);
    assign data_out = data_q;
endmodule

// File: rtl/operand_issue_stage.sv
// Holds one decoded instruction, reads its sources from the register file, stalls on reserved
// sources, reserves the destination on issue and owns the shared write-port address.
module operand_issue_stage
    import register_file_params::*;
    import issue_params::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  issue_instr_t                         in_instr,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rf_src0,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rf_src1,
    input  logic [OPERAND_WIDTH-1:0]             rf_op0,
    input  logic [OPERAND_WIDTH-1:0]             rf_op1,
    input  logic                                 rf_reserved,
    output logic                                 rf_write_reserve,
    output logic                                 rf_write_back,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rf_wb_register,
    output logic [OPERAND_WIDTH-1:0]             rf_result,
    input  logic                                 wb_valid,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] wb_register,
    input  logic [OPERAND_WIDTH-1:0]             wb_result,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [OPCODE_WIDTH-1:0]              out_opcode,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] out_dst,
    output logic [OPERAND_WIDTH-1:0]             out_op0,
    output logic [OPERAND_WIDTH-1:0]             out_op1
);
    logic         hold_valid;
    issue_instr_t hold_instr;
    logic         hold_needs_rsv;
    logic         issue;
    issue_out_t   issue_payload;
    issue_out_t   out_data;

    issue_slot #(.payload_t(issue_instr_t)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (in_valid && in_ready),
        .unload   (issue),
        .data_in  (in_instr),
        .valid    (hold_valid),
        .data_out (hold_instr)
    );

    issue_slot #(.payload_t(issue_out_t)) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (issue),
        .unload   (out_ready),
        .data_in  (issue_payload),
        .valid    (out_valid),
        .data_out (out_data)
    );

    assign rf_src0        = hold_instr.src0;
    assign rf_src1        = hold_instr.src1;
    assign hold_needs_rsv = needs_reservation(hold_instr);

    // A reservation needs the shared write port, which write-back always owns when active.
    assign issue = !rst && hold_valid && !rf_reserved && (!out_valid || out_ready)
                   && !(hold_needs_rsv && wb_valid);

    assign in_ready         = !hold_valid || issue;
    assign rf_write_reserve = issue && hold_needs_rsv;

    assign rf_write_back  = wb_valid;
    assign rf_wb_register = wb_valid ? wb_register : hold_instr.dst;
    assign rf_result      = wb_valid ? wb_result : '0;

    assign issue_payload = '{opcode: hold_instr.opcode, dst: hold_instr.dst, op0: rf_op0, op1: rf_op1};

    assign out_opcode = out_data.opcode;
    assign out_dst    = out_data.dst;
    assign out_op0    = out_data.op0;
    assign out_op1    = out_data.op1;
endmodule
